// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority arbiter.
// Holds the FSM state encoding and the rotating-mask helper.
package libsv_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_t;

   // Bit bitPos of the round-robin mask after idx has been served.
   // Bits strictly above idx stay eligible; serving the top requester wraps to all ones.
   function automatic logic wrapMaskBit(input int bitPos, input int idx, input int width);
      logic inRange;
      inRange = (bitPos >= 0) && (bitPos < width);
      return inRange && ((bitPos > idx) || (idx >= width - 1));
   endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant handshake bundle between requesters, the arbiter and the grant consumer.
interface rr_priority_arbiter_if #(
   parameter int WIDTH = 4
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] i_req;
   logic             i_rr_en;
   logic             i_lock;
   logic             i_ready;
   logic             o_valid;
   logic [WIDTH-1:0] o_grant;
   logic [IDX_W-1:0] o_grant_idx;

   modport master (
      output i_req, i_rr_en, i_lock, i_ready,
      input  o_valid, o_grant, o_grant_idx
   );

   modport slave (
      input  i_req, i_rr_en, i_lock, i_ready,
      output o_valid, o_grant, o_grant_idx
   );

endinterface

// File: rtl/rr_priority_arbiter_encoder.sv
// Lowest-set-bit one-hot priority encoder; bit 0 has the highest priority.
module onehot_priority_encoder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_req,
   output logic [WIDTH-1:0] o_grant,
   output logic             o_any
);

   // Two's-complement trick isolates the lowest set bit.
   assign o_grant = i_req & (~i_req + WIDTH'(1));
   assign o_any   = |i_req;

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered arbiter with valid/ready grant handshake, runtime fixed/round-robin
// selection and an optional grant lock for multi-beat transfers.
module rr_priority_arbiter
   import libsv_arbiter_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                  i_clock,
   input  logic                  i_areset,
   rr_priority_arbiter_if.slave  bus
);

   arbState_t        r_state;
   logic             r_valid;
   logic [WIDTH-1:0] r_grant;
   logic [IDX_W-1:0] r_grantIdx;
   logic [WIDTH-1:0] r_mask;

   logic [WIDTH-1:0] w_advMask;
   logic [WIDTH-1:0] w_useMask;
   logic [WIDTH-1:0] w_maskedReq;
   logic [WIDTH-1:0] w_selMasked;
   logic [WIDTH-1:0] w_selPlain;
   logic [WIDTH-1:0] w_sel;
   logic [IDX_W-1:0] w_selIdx;
   logic             w_anyMasked;
   logic             w_anyReq;
   logic             w_lockHold;

   // Mask that applies once the current grant has been consumed.
   always_comb begin
      w_advMask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_advMask[i] = wrapMaskBit(i, int'(r_grantIdx), WIDTH);
      end
   end

   // A handshake re-arbitrates against the advanced mask so there is no bubble.
   assign w_useMask   = (r_state == GRANT) ? w_advMask : r_mask;
   assign w_maskedReq = bus.i_req & w_useMask;

   onehot_priority_encoder #(.WIDTH(WIDTH)) u_encMasked (
      .i_req   (w_maskedReq),
      .o_grant (w_selMasked),
      .o_any   (w_anyMasked)
   );

   onehot_priority_encoder #(.WIDTH(WIDTH)) u_encPlain (
      .i_req   (bus.i_req),
      .o_grant (w_selPlain),
      .o_any   (w_anyReq)
   );

   assign w_sel = (bus.i_rr_en && w_anyMasked) ? w_selMasked : w_selPlain;

   always_comb begin
      w_selIdx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_sel[i]) begin
            w_selIdx = w_selIdx | IDX_W'(i);
         end
      end
   end

   assign w_lockHold = bus.i_lock && bus.i_req[r_grantIdx];

   always_ff @(posedge i_clock or posedge i_areset) begin
      if (i_areset) begin
         r_state    <= IDLE;
         r_valid    <= 1'b0;
         r_grant    <= '0;
         r_grantIdx <= '0;
         r_mask     <= '1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_state    <= GRANT;
                  r_valid    <= 1'b1;
                  r_grant    <= w_sel;
                  r_grantIdx <= w_selIdx;
               end
            end
            GRANT: begin
               // Without a handshake the grant is frozen, whatever the requests do.
               if (bus.i_ready && !w_lockHold) begin
                  if (bus.i_rr_en) begin
                     r_mask <= w_advMask;
                  end
                  if (w_anyReq) begin
                     r_grant    <= w_sel;
                     r_grantIdx <= w_selIdx;
                  end else begin
                     r_state    <= IDLE;
                     r_valid    <= 1'b0;
                     r_grant    <= '0;
                     r_grantIdx <= '0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_grant <= '0;
            end
         endcase
      end
   end

   assign bus.o_valid     = r_valid;
   assign bus.o_grant     = r_grant;
   assign bus.o_grant_idx = r_grantIdx;

   a_onehotGrant: assert property (@(posedge i_clock) disable iff (i_areset)
      r_valid |-> $onehot(r_grant));

   a_zeroWhenIdle: assert property (@(posedge i_clock) disable iff (i_areset)
      !r_valid |-> (r_grant == '0));

   a_stableUnderBackpressure: assert property (@(posedge i_clock) disable iff (i_areset)
      (r_valid && !bus.i_ready) |=> $stable(r_grant));

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter: each scenario queues expected grants
// as it drives stimulus and checks them against the registered outputs.
module tb_rr_priority_arbiter;

   localparam int WIDTH = 4;

   typedef struct packed {
      logic       valid;
      logic [3:0] grant;
      logic [1:0] idx;
   } expect_t;

   logic    clock = 1'b0;
   logic    areset;
   int      testsRun = 0;
   int      testsFailed = 0;
   expect_t scoreQ[$];
   expect_t exp;
   expect_t got;

   rr_priority_arbiter_if #(.WIDTH(WIDTH)) bus ();

   rr_priority_arbiter #(.WIDTH(WIDTH)) dut (
      .i_clock  (clock),
      .i_areset (areset),
      .bus      (bus)
   );

   always #5 clock = ~clock;

   function automatic expect_t mkExp(input logic [3:0] grant);
      expect_t e;
      e.valid = |grant;
      e.grant = grant;
      e.idx   = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (grant[i]) e.idx = e.idx | 2'(i);
      end
      return e;
   endfunction

   // Drive one cycle of inputs on the falling edge and queue what must appear after the next rising edge.
   task automatic applyStimulus(input logic [3:0] req, input logic rrEn, input logic lock,
                                input logic ready, input logic [3:0] expGrant);
      @(negedge clock);
      bus.i_req   = req;
      bus.i_rr_en = rrEn;
      bus.i_lock  = lock;
      bus.i_ready = ready;
      scoreQ.push_back(mkExp(expGrant));
   endtask

   task automatic doReset();
      @(negedge clock);
      areset      = 1'b1;
      bus.i_req   = '0;
      bus.i_rr_en = 1'b0;
      bus.i_lock  = 1'b0;
      bus.i_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      areset = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      areset = 1'b1;
      scoreQ.push_back(mkExp(4'b0000));
      @(posedge clock); #1;
      exp = scoreQ.pop_front();
      got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL reset_held: got %b expected %b", got, exp);
      end
      @(negedge clock);
      areset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
         @(posedge clock); #1;
         exp = scoreQ.pop_front();
         got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
         testsRun++;
         if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", c, got, exp);
         end
      end
   endtask

   task automatic test_fixed_priority();
      doReset();
      for (int c = 0; c < 6; c++) begin
         applyStimulus(4'b1110, 1'b0, 1'b0, 1'b1, 4'b0010);
         @(posedge clock); #1;
         exp = scoreQ.pop_front();
         got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
         testsRun++;
         if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL fixed_priority cycle %0d: got %b expected %b", c, got, exp);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] seq [8];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      doReset();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, seq[c]);
         @(posedge clock); #1;
         exp = scoreQ.pop_front();
         got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
         testsRun++;
         if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL round_robin cycle %0d: got %b expected %b", c, got, exp);
         end
      end
   endtask

   task automatic test_backpressure();
      doReset();
      for (int c = 0; c < 8; c++) begin
         if (c == 0)      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100);
         else if (c < 6)  applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'b0100);
         else if (c == 6) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001);
         else             applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
         @(posedge clock); #1;
         exp = scoreQ.pop_front();
         got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
         testsRun++;
         if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL backpressure cycle %0d: got %b expected %b", c, got, exp);
         end
      end
   endtask

   task automatic test_lock();
      doReset();
      for (int c = 0; c < 6; c++) begin
         if (c < 4)       applyStimulus(4'b0011, 1'b1, 1'b1, 1'b1, 4'b0001);
         else if (c == 4) applyStimulus(4'b0011, 1'b1, 1'b0, 1'b1, 4'b0010);
         else             applyStimulus(4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001);
         @(posedge clock); #1;
         exp = scoreQ.pop_front();
         got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
         testsRun++;
         if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL lock cycle %0d: got %b expected %b", c, got, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      doReset();
      applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000);
      @(posedge clock); #1;
      exp = scoreQ.pop_front();
      got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL async_reset_setup: got %b expected %b", got, exp);
      end
      @(negedge clock); #2;
      areset = 1'b1;
      scoreQ.push_back(mkExp(4'b0000));
      #1;
      exp = scoreQ.pop_front();
      got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL async_reset_immediate: got %b expected %b", got, exp);
      end
      @(negedge clock);
      bus.i_req = 4'b1001;
      areset    = 1'b0;
      scoreQ.push_back(mkExp(4'b0001));
      @(posedge clock); #1;
      exp = scoreQ.pop_front();
      got = {bus.o_valid, bus.o_grant, bus.o_grant_idx};
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL async_reset_regrant: got %b expected %b", got, exp);
      end
   endtask

   initial begin
      areset      = 1'b1;
      bus.i_req   = '0;
      bus.i_rr_en = 1'b0;
      bus.i_lock  = 1'b0;
      bus.i_ready = 1'b0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_backpressure();
      test_lock();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Sequential, parametrised successor to the combinational one-hot priority encoder.
- Arbitrates WIDTH requesters and produces a registered one-hot grant plus its binary index.
- Grants are offered to a downstream consumer with a valid/ready handshake.
- Runtime selection between fixed-priority (index 0 highest) and round-robin modes; optional grant lock for multi-beat transfers.
- Sits in front of shared resources: bus muxes, shared FIFOs, memory ports.

Parameters:
WIDTH, 4, number of requesters (>= 1)
IDX_W, (WIDTH > 1) ? $clog2(WIDTH) : 1, width of o_grant_idx (derived, not to be overridden)

Ports:
i_clock  input  1  clock, all state updates on rising edge
i_areset  input  1  asynchronous, active-high reset
i_req  input  WIDTH  request vector, bit i = requester i
i_rr_en  input  1  1 = round-robin, 0 = fixed priority (LSB wins)
i_lock  input  1  sampled at handshake; 1 = keep current grant for the next transfer
i_ready  input  1  consumer accepts the current grant
o_valid  output  1  grant is valid
o_grant  output  WIDTH  registered one-hot grant (all zero when o_valid=0)
o_grant_idx  output  IDX_W  binary index of o_grant (0 when o_valid=0)

Behaviour:
- Reset (async assert, sync-safe deassert): o_valid=0, o_grant=0, o_grant_idx=0, state=IDLE, rr mask=all ones (requester 0 first). An assertion mid-grant drops the grant immediately.
- States: IDLE (no grant outstanding), GRANT (o_valid=1, awaiting i_ready).
- Selection function sel(req):
  - fixed mode: lowest set bit of req.
  - rr mode: lowest set bit of (req & mask) if that is non-zero, else lowest set bit of req.
- IDLE: if |i_req, register o_grant=sel(i_req) and o_valid=1, then go to GRANT. Request-to-grant latency is 1 cycle. Otherwise stay in IDLE.
- GRANT, no handshake (i_ready=0): o_grant and o_grant_idx are held stable even if the granted i_req bit drops. No re-arbitration.
- GRANT, handshake (o_valid & i_ready):
  - If i_lock=1 and i_req[o_grant_idx]=1: grant unchanged, stay in GRANT, mask unchanged.
  - Otherwise, in rr mode, mask <= bits strictly above o_grant_idx; if o_grant_idx=WIDTH-1 the mask becomes all ones (wrap).
  - Re-arbitrate in the same cycle using the updated mask and current i_req. The granted requester remains eligible only if no other requester wins under the mask. This gives back-to-back grants with no bubble.
  - If no request: o_valid=0, o_grant=0, go to IDLE.
- Fixed mode leaves the mask unchanged. A change of i_rr_en takes effect at the next arbitration decision only, never mid-grant.
- WIDTH=1: mask logic degenerates; the grant is always bit 0 and idx 0.
- Invariants checked by assertions: $onehot(o_grant) when o_valid; o_grant==0 when !o_valid; o_grant stable while o_valid & !i_ready.

Decomposition:
- Package libsv_arbiter_pkg: state enum (IDLE, GRANT) and a function computing the wrap mask from an index.
- Sub-module: instantiate onehot_priority_encoder twice (masked and unmasked request vectors) for the lowest-set-bit selection.
- A small combinational onehot-to-binary conversion for o_grant_idx lives in this block.

Test Plan:
- Reset/idle: hold i_areset=1, then release with i_req=0 -> o_valid=0, o_grant=4'b0000, o_grant_idx=0 for 10 cycles.
- Fixed priority: i_rr_en=0, i_req=4'b1110, i_ready=1 constantly -> o_grant=4'b0010 every cycle after 1-cycle latency.
- Round-robin fairness: i_rr_en=1, i_req=4'b1111, i_ready=1 -> grants cycle 0001, 0010, 0100, 1000, 0001 (wrap), with no bubbles.
- Backpressure: grant 4'b0100 outstanding, i_ready=0 for 5 cycles, i_req changes to 4'b0001 -> o_grant stays 4'b0100 and o_valid=1 until i_ready. Next grant is 4'b0001.
- Lock: i_rr_en=1, i_req=4'b0011, grant 0001, i_lock=1 for 3 handshakes -> 0001 held for 3 transfers. i_lock=0 then -> next grant 0010.
- Async reset mid-grant: o_valid=1, o_grant=4'b1000, assert i_areset between edges -> outputs zero immediately. After release with i_req=4'b1001 -> first grant 4'b0001.
